// File: rtl/adder_error_monitor.sv
// adder_error_monitor: streams (X, Y, S, Co) samples from an approximate adder and
// accumulates error statistics over a 2^LOG2_SAMPLES window.
module adder_error_monitor #(
    parameter int N            = 16,
    parameter int LOG2_SAMPLES = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              X,
    input  logic [N-1:0]              Y,
    input  logic [N-1:0]              S,
    input  logic                      Co,
    output logic                      busy,
    output logic                      done,
    output logic [LOG2_SAMPLES:0]     err_count,
    output logic [N+LOG2_SAMPLES-1:0] sum_ed,
    output logic [N-1:0]              max_ed,
    output logic [LOG2_SAMPLES:0]     zero_count,
    output logic [N-1:0]              med
);
    localparam int L = LOG2_SAMPLES;
    typedef logic [L:0] cnt_t;
    typedef logic [N+L-1:0] sum_t;
    localparam cnt_t WIN  = {1'b1, {L{1'b0}}};
    localparam cnt_t LAST = {1'b0, {L{1'b1}}};
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t       state_q, state_d;
    cnt_t         cnt_q, cnt_d, err_q, err_d, zero_q, zero_d;
    sum_t         sum_q, sum_d;
    logic [N-1:0] max_q, max_d, med_q, med_d, ed1_q, ed2_q;
    logic         v1_q, mis1_q, zero1_q, v2_q, mis2_q, zero2_q;
    logic [N:0]   exact;
    logic         accept, clear;
    assign exact      = {1'b0, X} + {1'b0, Y};
    assign in_ready   = (state_q == RUN) && (cnt_q < WIN);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = state_q == DONE;
    assign err_count  = err_q;
    assign sum_ed     = sum_q;
    assign max_ed     = max_q;
    assign zero_count = zero_q;
    assign med        = med_q;
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = RUN;
                clear   = 1'b1;
            end
            RUN:     if (accept && cnt_q == LAST) state_d = DRAIN;
            DRAIN:   if (!v1_q && !v2_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
        cnt_d  = clear ? '0 : cnt_q + cnt_t'(accept);
        err_d  = clear ? '0 : err_q + cnt_t'(v2_q && mis2_q);
        zero_d = clear ? '0 : zero_q + cnt_t'(v2_q && zero2_q);
        sum_d  = clear ? '0 : sum_q + (v2_q ? sum_t'(ed2_q) : '0);
        max_d  = clear ? '0 : (v2_q && ed2_q > max_q) ? ed2_q : max_q;
        // sum_q is final by the time DRAIN exits, so the mean is captured on that edge
        med_d  = clear ? '0 : (state_q == DRAIN && state_d == DONE) ? sum_q[N+L-1:L] : med_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            zero_q  <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            med_q   <= '0;
            v1_q    <= 1'b0;
            ed1_q   <= '0;
            mis1_q  <= 1'b0;
            zero1_q <= 1'b0;
            v2_q    <= 1'b0;
            ed2_q   <= '0;
            mis2_q  <= 1'b0;
            zero2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            med_q   <= med_d;
            v1_q    <= accept;
            ed1_q   <= (S > exact[N-1:0]) ? S - exact[N-1:0] : exact[N-1:0] - S;
            mis1_q  <= (S != exact[N-1:0]) || (Co != exact[N]);
            zero1_q <= exact[N-1:0] == '0;
            v2_q    <= v1_q;
            ed2_q   <= ed1_q;
            mis2_q  <= mis1_q;
            zero2_q <= zero1_q;
        end
    end
endmodule
